// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: shares one 1-cycle-latency memory port between the
// core fetch unit, the core load/store unit and a debug program loader.
module imem_access_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_req,
   input  logic [ADDR_WIDTH-1:0]     if_addr,
   output logic                      if_gnt,
   output logic                      if_rvalid,
   output logic [DATA_WIDTH-1:0]     if_rdata,
   input  logic                      ls_req,
   input  logic                      ls_we,
   input  logic [DATA_WIDTH/8-1:0]   ls_be,
   input  logic [ADDR_WIDTH-1:0]     ls_addr,
   input  logic [DATA_WIDTH-1:0]     ls_wdata,
   output logic                      ls_gnt,
   output logic                      ls_rvalid,
   output logic [DATA_WIDTH-1:0]     ls_rdata,
   input  logic                      dbg_halt,
   input  logic                      dbg_req,
   input  logic                      dbg_we,
   input  logic [ADDR_WIDTH-1:0]     dbg_addr,
   input  logic [DATA_WIDTH-1:0]     dbg_wdata,
   output logic                      dbg_gnt,
   output logic                      dbg_rvalid,
   output logic [DATA_WIDTH-1:0]     dbg_rdata,
   output logic                      halted,
   output logic                      core_stall,
   output logic                      mem_en,
   output logic [DATA_WIDTH/8-1:0]   mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [DATA_WIDTH-1:0]     mem_rdata
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = 4;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [CNT_WIDTH-1:0]  r_starve;
   logic [CNT_WIDTH-1:0]  w_starve_nxt;
   logic                  r_if_rvalid;
   logic                  r_ls_rvalid;
   logic                  r_dbg_rvalid;
   logic                  r_halted;

   logic                  w_if_gnt;
   logic                  w_ls_gnt;
   logic                  w_dbg_gnt;
   logic                  w_is_read;
   logic [BE_WIDTH-1:0]   w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;
   logic                  w_starve_max;

   assign w_starve_max = (r_starve == CNT_MAX);

   // State, starvation counter, read-response owner flags and halted flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_RUN;
         r_starve     <= '0;
         r_if_rvalid  <= 1'b0;
         r_ls_rvalid  <= 1'b0;
         r_dbg_rvalid <= 1'b0;
         r_halted     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve     <= w_starve_nxt;
         r_if_rvalid  <= w_if_gnt  & w_is_read;
         r_ls_rvalid  <= w_ls_gnt  & w_is_read;
         r_dbg_rvalid <= w_dbg_gnt & w_is_read;
         r_halted     <= (w_state_nxt == ST_HALT);
      end
   end

   // Next state, grant selection and memory port mux; grants forced low in reset
   always_comb begin
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve;
      w_if_gnt     = 1'b0;
      w_ls_gnt     = 1'b0;
      w_dbg_gnt    = 1'b0;
      w_is_read    = 1'b0;
      w_mem_we     = '0;
      w_mem_addr   = '0;
      w_mem_wdata  = '0;

      if (rst_n) begin
         case (r_state)
            ST_RUN: begin
               if (dbg_halt) begin
                  w_state_nxt = ST_DRAIN;
               end else if (ls_req && !(w_starve_max && if_req)) begin
                  w_ls_gnt = 1'b1;
               end else if (if_req) begin
                  w_if_gnt = 1'b1;
               end
               // Count consecutive denied fetch cycles, saturating at the limit
               if (if_req && !w_if_gnt) begin
                  if (!w_starve_max) w_starve_nxt = r_starve + CNT_WIDTH'(1);
               end else begin
                  w_starve_nxt = '0;
               end
            end
            ST_DRAIN: begin
               w_state_nxt = ST_HALT;
            end
            ST_HALT: begin
               w_dbg_gnt = dbg_req;
               if (!dbg_halt) w_state_nxt = ST_RUN;
            end
            default: begin
               w_state_nxt = ST_RUN;
            end
         endcase
      end

      if (w_ls_gnt) begin
         w_mem_addr  = ls_addr;
         w_mem_wdata = ls_wdata;
         w_mem_we    = ls_we ? ls_be : '0;
         w_is_read   = !ls_we;
      end else if (w_if_gnt) begin
         w_mem_addr  = if_addr;
         w_is_read   = 1'b1;
      end else if (w_dbg_gnt) begin
         w_mem_addr  = dbg_addr;
         w_mem_wdata = dbg_wdata;
         w_mem_we    = dbg_we ? '1 : '0;
         w_is_read   = !dbg_we;
      end
   end

   assign if_gnt     = w_if_gnt;
   assign ls_gnt     = w_ls_gnt;
   assign dbg_gnt    = w_dbg_gnt;
   assign mem_en     = w_if_gnt | w_ls_gnt | w_dbg_gnt;
   assign mem_we     = w_mem_we;
   assign mem_addr   = w_mem_addr;
   assign mem_wdata  = w_mem_wdata;

   assign if_rvalid  = r_if_rvalid;
   assign ls_rvalid  = r_ls_rvalid;
   assign dbg_rvalid = r_dbg_rvalid;
   assign if_rdata   = mem_rdata;
   assign ls_rdata   = mem_rdata;
   assign dbg_rdata  = mem_rdata;
   assign halted     = r_halted;

   assign core_stall = (r_state != ST_RUN) || dbg_halt ||
                       (if_req && !w_if_gnt) || (ls_req && !w_ls_gnt);

endmodule

// File: tb/tb_imem_access_arbiter.sv
// Directed testbench for imem_access_arbiter with a small behavioural BRAM.
module tb_imem_access_arbiter;

   logic        clk;
   logic        rst_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        ls_req, ls_we;
   logic [3:0]  ls_be;
   logic [31:0] ls_addr, ls_wdata;
   logic        ls_gnt, ls_rvalid;
   logic [31:0] ls_rdata;
   logic        dbg_halt, dbg_req, dbg_we;
   logic [31:0] dbg_addr, dbg_wdata;
   logic        dbg_gnt, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        halted, core_stall, mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic [31:0] mem [0:255];
   int          n_total;
   int          n_bad;

   imem_access_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr),
      .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .dbg_halt(dbg_halt), .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
      .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
      .dbg_rdata(dbg_rdata), .halted(halted), .core_stall(core_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous BRAM: byte-enabled writes, read data one cycle after mem_en
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
               if (mem_we[b]) mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= mem[mem_addr[9:2]];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge, where inputs are driven
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Move to the falling edge, where outputs are sampled
   task automatic sample_point();
      @(negedge clk);
   endtask

   initial begin
      n_total   = 0;
      n_bad     = 0;
      mem_rdata = '0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h01B00D93;
      mem[1] = 32'h01C00E13;
      mem[2] = 32'hA5A5A5A5;

      // 1. reset with every request high
      rst_n    = 1'b0;
      if_req   = 1'b1; if_addr  = 32'h0;
      ls_req   = 1'b1; ls_we    = 1'b0; ls_be = 4'h0; ls_addr = 32'h8; ls_wdata = 32'h0;
      dbg_halt = 1'b0; dbg_req  = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
      next_cycle();
      sample_point();
      chk("rst_gnts",   {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
      chk("rst_rvalid", {29'd0, if_rvalid, ls_rvalid, dbg_rvalid}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      next_cycle();
      rst_n = 1'b1;
      sample_point();
      chk("first_gnt_lsu", {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'b010);
      next_cycle();
      if_req = 1'b0; ls_req = 1'b0; dbg_req = 1'b0;
      sample_point();

      // 2. IFU alone, back-to-back fetches
      next_cycle();
      if_req = 1'b1; if_addr = 32'h0;
      sample_point();
      chk("ifu_gnt0",   {31'd0, if_gnt}, 32'd1);
      chk("ifu_stall0", {31'd0, core_stall}, 32'd0);
      next_cycle();
      if_addr = 32'h4;
      sample_point();
      chk("ifu_gnt1",    {31'd0, if_gnt}, 32'd1);
      chk("ifu_rvalid0", {31'd0, if_rvalid}, 32'd1);
      chk("ifu_rdata0",  if_rdata, 32'h01B00D93);
      chk("ifu_stall1",  {31'd0, core_stall}, 32'd0);
      next_cycle();
      if_req = 1'b0;
      sample_point();
      chk("ifu_rvalid1", {31'd0, if_rvalid}, 32'd1);
      chk("ifu_rdata1",  if_rdata, 32'h01C00E13);

      // 3. IFU and LSU both requesting: four LSU grants then one IFU grant
      next_cycle();
      if_req = 1'b1; if_addr = 32'h0;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8;
      for (int k = 0; k < 10; k++) begin
         sample_point();
         chk($sformatf("starve_k%0d", k), {30'd0, if_gnt, ls_gnt},
             (k % 5 == 4) ? 32'b10 : 32'b01);
         next_cycle();
      end

      // 4. LSU partial write
      if_req = 1'b0;
      ls_req = 1'b1; ls_we = 1'b1; ls_be = 4'b0011; ls_addr = 32'h100; ls_wdata = 32'hDEADBEEF;
      sample_point();
      chk("lsw_gnt",   {31'd0, ls_gnt}, 32'd1);
      chk("lsw_we",    {28'd0, mem_we}, 32'h3);
      chk("lsw_addr",  mem_addr, 32'h100);
      chk("lsw_wdata", mem_wdata, 32'hDEADBEEF);
      next_cycle();
      ls_req = 1'b0; ls_we = 1'b0; ls_be = 4'h0;
      sample_point();
      chk("lsw_no_rvalid", {31'd0, ls_rvalid}, 32'd0);

      // 5. halt, drain, loader write/read, resume
      next_cycle();
      if_req = 1'b1; if_addr = 32'h4;
      sample_point();
      chk("h_if_gnt", {31'd0, if_gnt}, 32'd1);
      next_cycle();
      if_req = 1'b0; dbg_halt = 1'b1;
      sample_point();
      chk("h_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("h_no_gnt",    {31'd0, mem_en}, 32'd0);
      chk("h_stall",     {31'd0, core_stall}, 32'd1);
      next_cycle();
      if_req = 1'b1;
      sample_point();
      chk("drain_no_gnt", {31'd0, mem_en}, 32'd0);
      chk("drain_halted", {31'd0, halted}, 32'd0);
      next_cycle();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'h00000013;
      sample_point();
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("dbgw_gnts",   {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'b001);
      chk("dbgw_we",     {28'd0, mem_we}, 32'hF);
      chk("dbgw_wdata",  mem_wdata, 32'h00000013);
      next_cycle();
      dbg_we = 1'b0;
      sample_point();
      chk("dbgr_gnt", {31'd0, dbg_gnt}, 32'd1);
      chk("dbgr_we",  {28'd0, mem_we}, 32'h0);
      next_cycle();
      dbg_req = 1'b0;
      sample_point();
      chk("dbgr_rvalid", {31'd0, dbg_rvalid}, 32'd1);
      chk("dbgr_rdata",  dbg_rdata, 32'h00000013);
      next_cycle();
      dbg_halt = 1'b0; dbg_req = 1'b1; dbg_addr = 32'h8;
      sample_point();
      chk("exit_dbg_gnt", {29'd0, if_gnt, ls_gnt, dbg_gnt}, 32'b001);
      next_cycle();
      dbg_req = 1'b0;
      sample_point();
      chk("run_if_gnt",     {31'd0, if_gnt}, 32'd1);
      chk("run_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
      chk("run_dbg_rdata",  dbg_rdata, 32'hA5A5A5A5);
      chk("run_halted",     {31'd0, halted}, 32'd0);

      // 6. reset asserted in HALT with a loader read response pending
      next_cycle();
      if_req = 1'b0; dbg_halt = 1'b1;
      next_cycle();
      next_cycle();
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0;
      sample_point();
      chk("r6_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
      next_cycle();
      chk("r6_pre_rvalid", {31'd0, dbg_rvalid}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("r6_rvalid_drop", {31'd0, dbg_rvalid}, 32'd0);
      chk("r6_halted_drop", {31'd0, halted}, 32'd0);
      chk("r6_gnt_low",     {31'd0, dbg_gnt}, 32'd0);
      next_cycle();
      rst_n = 1'b1; dbg_halt = 1'b0; dbg_req = 1'b0;
      if_req = 1'b1; if_addr = 32'h4;
      sample_point();
      chk("r6_run_if_gnt", {31'd0, if_gnt}, 32'd1);
      chk("r6_no_stale",   {29'd0, if_rvalid, ls_rvalid, dbg_rvalid}, 32'd0);
      next_cycle();
      if_req = 1'b0;
      sample_point();
      chk("r6_if_rvalid",  {30'd0, if_rvalid, dbg_rvalid}, 32'b10);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
